// File: rtl/lpc_sniffer_pkg.sv
// lpc_sniffer_pkg: record format, marker layout and capture FSM state codes
package lpc_sniffer_pkg;

    localparam int RECORD_W = 48;
    localparam logic [3:0] CYC_MARKER = 4'hF;
    localparam int MARK_CNT_LO = 8;
    localparam int MARK_CNT_HI = 23;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DROP = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    function automatic logic [RECORD_W-1:0] marker(input logic [15:0] cnt);
        logic [RECORD_W-1:0] m;
        m = '0;
        m[MARK_CNT_HI:MARK_CNT_LO] = cnt;
        m[3:0] = CYC_MARKER;
        return m;
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: record input, ring buffer write side and status of the capture controller
interface capture_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 48
);
    logic [DW-1:0] in_data;
    logic          in_enable;
    logic          capture_enable;
    logic [15:0]   filter_mask;
    logic          read_clock_enable;
    logic [DW-1:0] write_data;
    logic          write_clock_enable;
    logic [AW:0]   level;
    logic          overflow;

    modport slave (
        input  in_data, in_enable, capture_enable, filter_mask, read_clock_enable,
        output write_data, write_clock_enable, level, overflow
    );

    modport master (
        output in_data, in_enable, capture_enable, filter_mask, read_clock_enable,
        input  write_data, write_clock_enable, level, overflow
    );
endinterface

// File: rtl/fifo_level.sv
// fifo_level: up/down occupancy counter with full flag for a ring buffer with one reserved slot
module fifo_level #(
    parameter int AW = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    output logic [AW:0] level,
    output logic        full
);
    localparam logic [AW:0] DEPTH = {1'b0, {AW{1'b1}}};

    assign full = (level == DEPTH);

    // a read against an empty buffer is ignored rather than wrapping
    always_ff @(posedge clock) begin
        if (reset)
            level <= '0;
        else if (inc && !dec)
            level <= level + 1'b1;
        else if (dec && !inc && level != '0)
            level <= level - 1'b1;
    end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: filters LPC records into the ring buffer; on overflow counts drops
// and writes a drop-marker record before capture resumes
module capture_ctrl
    import lpc_sniffer_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = RECORD_W
) (
    input logic          clock,
    input logic          reset,
    capture_ctrl_if.slave bus
);
    logic [1:0]    state, state_n;
    logic [15:0]   cnt, cnt_n, cnt_inc;
    logic [DW-1:0] hold, hold_n, wd_n;
    logic          wr, drop, acc, space, full;

    assign acc = bus.in_enable && bus.capture_enable && bus.filter_mask[bus.in_data[3:0]] &&
                 bus.in_data[3:0] != CYC_MARKER;
    assign space = !full || bus.read_clock_enable;
    assign cnt_inc = &cnt ? cnt : cnt + 16'd1;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        hold_n = hold;
        wd_n = bus.write_data;
        wr = 1'b0;
        drop = 1'b0;
        case (state)
            IDLE: begin
                wr = acc && space;
                drop = acc && !space;
                wd_n = wr ? bus.in_data : bus.write_data;
                cnt_n = drop ? 16'd1 : cnt;
                state_n = drop ? DROP : IDLE;
            end
            DROP: begin
                wr = space;
                drop = acc && !space;
                wd_n = space ? marker(cnt) : bus.write_data;
                cnt_n = space ? 16'd0 : drop ? cnt_inc : cnt;
                hold_n = (space && acc) ? bus.in_data : hold;
                state_n = !space ? DROP : acc ? HOLD : IDLE;
            end
            HOLD: begin
                // a record arriving while the hold slot is occupied is always lost
                wr = space;
                drop = acc || !space;
                wd_n = space ? hold : bus.write_data;
                cnt_n = space ? (acc ? 16'd1 : 16'd0) : (acc ? 16'd2 : 16'd1);
                state_n = (space && !acc) ? IDLE : DROP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            hold <= '0;
            bus.write_data <= '0;
            bus.write_clock_enable <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            hold <= hold_n;
            bus.write_data <= wd_n;
            bus.write_clock_enable <= wr;
            bus.overflow <= bus.overflow || drop;
        end
    end

    // level counts a write on the decision edge so the next space check already sees it
    fifo_level #(.AW(AW)) u_level (
        .clock(clock),
        .reset(reset),
        .inc  (wr),
        .dec  (bus.read_clock_enable),
        .level(bus.level),
        .full (full)
    );
endmodule
